// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address + R/W, one data byte (write or read), STOP.
// Each bit slot is four quarters of CLK_DIV cycles; SCL is push-pull, SDA open-drain.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 125
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [6:0] i_addr,
    input  logic [7:0] i_wrdata,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_err,
    output logic [7:0] o_rddata,
    output logic       o_scl,
    inout  wire        io_sda
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE,
        S_WR_ACK, S_READ, S_RD_NACK, S_STOP, S_DONE
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   tick, tick_n;
    logic [1:0]      quarter, quarter_n;
    logic [2:0]      bit_cnt, bit_cnt_n;
    logic [7:0]      tx_sr, tx_sr_n;
    logic [7:0]      rx_sr;
    logic [7:0]      wrdata_q;
    logic            rw_q;
    logic            ack_err_pend;
    logic            addr_nack;
    logic            sda_low, sda_low_n;
    logic            scl_n, busy_n, done_n;
    logic            qtr_end, slot_end, smp_pt, sda_in;

    assign qtr_end  = (tick == TICK_LAST);
    assign slot_end = qtr_end && (quarter == 2'd3);
    assign smp_pt   = qtr_end && (quarter == 2'd2);
    assign sda_in   = io_sda;
    assign io_sda   = sda_low ? 1'b0 : 1'bz;

    always_comb begin
        state_n   = state;
        tick_n    = '0;
        quarter_n = '0;
        bit_cnt_n = bit_cnt;
        tx_sr_n   = tx_sr;

        if (state != S_IDLE && state != S_DONE) begin
            tick_n    = qtr_end ? '0 : tick + 1'b1;
            quarter_n = qtr_end ? quarter + 2'd1 : quarter;
        end

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_n = S_START;
                    tx_sr_n = {i_addr, i_rw};
                end
            end
            S_START: begin
                if (slot_end) begin
                    state_n   = S_ADDR;
                    bit_cnt_n = '0;
                end
            end
            S_ADDR, S_WRITE: begin
                if (slot_end) begin
                    tx_sr_n   = {tx_sr[6:0], 1'b0};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_n = (state == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
                end
            end
            S_ADDR_ACK: begin
                if (slot_end) begin
                    if (addr_nack)
                        state_n = S_STOP;
                    else if (rw_q)
                        state_n = S_READ;
                    else begin
                        state_n = S_WRITE;
                        tx_sr_n = wrdata_q;
                    end
                end
            end
            S_READ: begin
                if (slot_end) begin
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_n = S_RD_NACK;
                end
            end
            S_WR_ACK, S_RD_NACK: begin
                if (slot_end)
                    state_n = S_STOP;
            end
            S_STOP: begin
                if (slot_end)
                    state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Bus pins are registered from the next state so they never glitch on decode.
        scl_n     = 1'b1;
        sda_low_n = 1'b0;
        case (state_n)
            S_START: sda_low_n = quarter_n[1];
            S_ADDR, S_WRITE: begin
                scl_n     = quarter_n[0] ^ quarter_n[1];
                sda_low_n = ~tx_sr_n[7];
            end
            S_ADDR_ACK, S_WR_ACK, S_READ, S_RD_NACK:
                scl_n = quarter_n[0] ^ quarter_n[1];
            S_STOP: begin
                scl_n     = (quarter_n != 2'd0);
                sda_low_n = (quarter_n != 2'd3);
            end
            default: ;
        endcase
        busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
        done_n = (state_n == S_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            tick    <= '0;
            quarter <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            o_scl   <= 1'b1;
            sda_low <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state   <= state_n;
            tick    <= tick_n;
            quarter <= quarter_n;
            bit_cnt <= bit_cnt_n;
            tx_sr   <= tx_sr_n;
            o_scl   <= scl_n;
            sda_low <= sda_low_n;
            o_busy  <= busy_n;
            o_done  <= done_n;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rw_q         <= 1'b0;
            wrdata_q     <= '0;
            rx_sr        <= '0;
            ack_err_pend <= 1'b0;
            addr_nack    <= 1'b0;
            o_ack_err    <= 1'b0;
            o_rddata     <= '0;
        end else begin
            if (state == S_IDLE && i_start) begin
                rw_q         <= i_rw;
                wrdata_q     <= i_wrdata;
                ack_err_pend <= 1'b0;
                addr_nack    <= 1'b0;
                o_ack_err    <= 1'b0;
            end
            if (smp_pt) begin
                if (state == S_ADDR_ACK && sda_in) begin
                    ack_err_pend <= 1'b1;
                    addr_nack    <= 1'b1;
                end
                if (state == S_WR_ACK && sda_in)
                    ack_err_pend <= 1'b1;
                if (state == S_READ)
                    rx_sr <= {rx_sr[6:0], sda_in};
            end
            // Results become visible together with the done pulse.
            if (state == S_STOP && slot_end) begin
                o_ack_err <= ack_err_pend;
                if (rw_q && !addr_nack)
                    o_rddata <= rx_sr;
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: two instances (CLK_DIV=4 and CLK_DIV=1) sharing one behavioural
// I2C slave/bus monitor at address 0x50, checked against a transaction-level model.
module tb_i2c_master_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start4 = 1'b0, rw4 = 1'b0, start1 = 1'b0, rw1 = 1'b0;
    logic [6:0] addr4 = '0, addr1 = '0;
    logic [7:0] wd4 = '0, wd1 = '0;
    logic       busy4, done4, aerr4, scl4, busy1, done1, aerr1, scl1;
    logic [7:0] rd4, rd1;
    wire        sda4, sda1;

    i2c_master_ctrl #(.CLK_DIV(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start4), .i_rw(rw4), .i_addr(addr4),
        .i_wrdata(wd4), .o_busy(busy4), .o_done(done4), .o_ack_err(aerr4),
        .o_rddata(rd4), .o_scl(scl4), .io_sda(sda4)
    );

    i2c_master_ctrl #(.CLK_DIV(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_rw(rw1), .i_addr(addr1),
        .i_wrdata(wd1), .o_busy(busy1), .o_done(done1), .o_ack_err(aerr1),
        .o_rddata(rd1), .o_scl(scl1), .io_sda(sda1)
    );

    pullup (sda4);
    pullup (sda1);

    logic       slave_low = 1'b0;
    logic       sel1 = 1'b0;
    logic [7:0] slv_rd_byte = '0;
    logic       slv_ack_data = 1'b1;
    assign sda4 = (slave_low && !sel1) ? 1'b0 : 1'bz;
    assign sda1 = (slave_low && sel1) ? 1'b0 : 1'bz;

    // Slave + monitor, sampling the selected bus on the falling clock edge.
    logic       mscl, msda;
    logic       pscl = 1'b1, psda = 1'b1;
    int         bitn = 0, byte_no = 0, starts = 0, stops = 0, bad_edges = 0;
    logic       addressed = 1'b0, rd_mode = 1'b0;
    logic [7:0] cur = '0;
    logic [7:0] bytes[$];
    logic       ninth[$];
    assign mscl = sel1 ? scl1 : scl4;
    assign msda = sel1 ? sda1 : sda4;

    always @(negedge clk) begin
        if (mscl && pscl && psda && !msda) begin
            starts++;
            bitn = 0; byte_no = 0; addressed = 1'b0; rd_mode = 1'b0; slave_low = 1'b0;
        end else if (mscl && pscl && !psda && msda)
            stops++;
        else if (mscl && (msda != psda))
            bad_edges++;
        if (mscl && !pscl) begin
            if (bitn < 8) begin
                cur = {cur[6:0], msda};
                bitn++;
                if (bitn == 8) bytes.push_back(cur);
            end else begin
                ninth.push_back(msda);
                bitn = 0;
                byte_no++;
            end
        end
        if (!mscl && pscl) begin
            slave_low = 1'b0;
            if (bitn == 8) begin
                if (byte_no == 0) begin
                    addressed = (cur[7:1] == 7'h50);
                    rd_mode   = cur[0];
                    slave_low = addressed;
                end else if (addressed && !rd_mode)
                    slave_low = slv_ack_data;
            end else if (addressed && rd_mode && byte_no == 1)
                slave_low = !slv_rd_byte[3'(7 - bitn)];
        end
        pscl = mscl;
        psda = msda;
    end

    int total = 0, bad = 0;
    logic [7:0] mrd4 = '0, mrd1 = '0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic use1, input logic st, input logic rw,
                         input logic [6:0] addr, input logic [7:0] wd);
        if (use1) begin start1 = st; rw1 = rw; addr1 = addr; wd1 = wd; end
        else      begin start4 = st; rw4 = rw; addr4 = addr; wd4 = wd; end
    endtask

    task automatic run_txn(input string tag, input logic use1, input logic rw,
                           input logic [6:0] addr, input logic [7:0] wd, input logic [7:0] rdb,
                           input logic ack_en, input int poke_at, input logic poke_done);
        int d, n, limit, exp_lat, b0, n0, s0, p0, e0;
        logic addr_ok, exp_err, gap;
        logic [7:0] exp_rd;
        d       = use1 ? 1 : 4;
        addr_ok = (addr == 7'h50);
        exp_lat = addr_ok ? 80 * d : 44 * d;
        exp_err = !addr_ok || (!rw && !ack_en);
        exp_rd  = use1 ? mrd1 : mrd4;
        if (rw && addr_ok) exp_rd = rdb;
        sel1 = use1; slv_rd_byte = rdb; slv_ack_data = ack_en;

        @(negedge clk);
        b0 = bytes.size(); n0 = ninth.size(); s0 = starts; p0 = stops; e0 = bad_edges;
        drive(use1, 1'b1, rw, addr, wd);
        @(posedge clk); #1;
        drive(use1, 1'b0, ~rw, 7'($urandom), 8'($urandom));
        check({tag, "_busy_acc"}, int'(use1 ? busy1 : busy4), 1);
        check({tag, "_err_clr"}, int'(use1 ? aerr1 : aerr4), 0);

        n = 0; gap = 1'b0; limit = 100 * d + 50;
        while (!(use1 ? done1 : done4) && n < limit) begin
            if (!(use1 ? busy1 : busy4)) gap = 1'b1;
            if (use1) start1 = (n == poke_at); else start4 = (n == poke_at);
            @(posedge clk); #1;
            n++;
        end
        drive(use1, 1'b0, rw, addr, wd);
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_busy_gap"}, int'(gap), 0);
        check({tag, "_busy_at_done"}, int'(use1 ? busy1 : busy4), 0);
        check({tag, "_ack_err"}, int'(use1 ? aerr1 : aerr4), int'(exp_err));
        check({tag, "_rddata"}, int'(use1 ? rd1 : rd4), int'(exp_rd));
        if (use1) mrd1 = exp_rd; else mrd4 = exp_rd;

        if (poke_done) begin
            if (use1) start1 = 1'b1; else start4 = 1'b1;
        end
        @(posedge clk); #1;
        drive(use1, 1'b0, rw, addr, wd);
        check({tag, "_done_pulse"}, int'(use1 ? done1 : done4), 0);
        repeat (12 * d + 4) @(negedge clk);
        check({tag, "_idle_after"}, int'(use1 ? busy1 : busy4), 0);
        check({tag, "_starts"}, starts - s0, 1);
        check({tag, "_stops"}, stops - p0, 1);
        check({tag, "_sda_rules"}, bad_edges - e0, 0);
        check({tag, "_nbytes"}, bytes.size() - b0, addr_ok ? 2 : 1);
        if (bytes.size() > b0 && ninth.size() > n0) begin
            check({tag, "_byte0"}, int'(bytes[b0]), int'({addr, rw}));
            check({tag, "_ack0"}, int'(ninth[n0]), int'(!addr_ok));
        end
        if (addr_ok && bytes.size() > b0 + 1 && ninth.size() > n0 + 1) begin
            check({tag, "_byte1"}, int'(bytes[b0 + 1]), int'(rw ? rdb : wd));
            check({tag, "_ack1"}, int'(ninth[n0 + 1]), int'(rw ? 1'b1 : !ack_en));
        end
    endtask

    initial begin
        logic       r_rw, r_ack, r_u;
        logic [6:0] r_addr;
        logic [7:0] r_wd, r_rdb;
        int         t0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", int'(scl4), 1);
        check("rst_sda", int'(sda4), 1);
        check("rst_busy", int'(busy4), 0);
        check("rst_done", int'(done4), 0);
        check("rst_err", int'(aerr4), 0);
        check("rst_rd", int'(rd4), 0);
        @(negedge clk);
        rst = 1'b0;

        run_txn("wr_a5", 1'b0, 1'b0, 7'h50, 8'hA5, 8'h00, 1'b1, -1, 1'b0);
        run_txn("rd_3c", 1'b0, 1'b1, 7'h50, 8'h00, 8'h3C, 1'b1, -1, 1'b0);
        run_txn("nack51", 1'b0, 1'b1, 7'h51, 8'h00, 8'h99, 1'b1, -1, 1'b0);
        run_txn("ignore", 1'b0, 1'b0, 7'h50, 8'h96, 8'h00, 1'b1, 20, 1'b1);
        run_txn("wr_nack", 1'b0, 1'b0, 7'h50, 8'h0F, 8'h00, 1'b0, -1, 1'b0);

        // Reset during WRITE bit 3, Q3 (SCL low, master driving SDA low).
        sel1 = 1'b0; slv_ack_data = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 7'h50, 8'hA5);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 7'h50, 8'hA5);
        t0 = 0;
        repeat (221) begin @(posedge clk); t0++; end
        #1;
        check("mid_scl_low", int'(scl4), 0);
        check("mid_sda_low", int'(sda4), 0);
        rst = 1'b1;
        #1;
        check("mid_rst_scl", int'(scl4), 1);
        check("mid_rst_sda", int'(sda4), 1);
        check("mid_rst_busy", int'(busy4), 0);
        check("mid_rst_rd", int'(rd4), 0);
        mrd4 = '0; mrd1 = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        run_txn("after_rst", 1'b0, 1'b0, 7'h50, 8'h5A, 8'h00, 1'b1, -1, 1'b0);

        run_txn("div1_ff", 1'b1, 1'b0, 7'h50, 8'hFF, 8'h00, 1'b1, -1, 1'b0);

        for (int k = 0; k < 10; k++) begin
            r_u    = (k >= 7);
            r_rw   = 1'($urandom);
            r_ack  = ($urandom_range(0, 3) != 0);
            r_addr = ($urandom_range(0, 2) != 0) ? 7'h50 : 7'($urandom);
            r_wd   = 8'($urandom);
            r_rdb  = 8'($urandom);
            run_txn($sformatf("rnd%0d", k), r_u, r_rw, r_addr, r_wd, r_rdb, r_ack, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
